// File: rtl/core_param_loader.sv
// core_param_loader: turns framed load commands into per-core param/instruction writes.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum word on each frame.
module core_param_loader #(
    parameter int NUM_CORES = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 err_clr,
    output logic [NUM_CORES-1:0] param_wen,
    output logic [31:0]          param_data_out,
    output logic [NUM_CORES-1:0] neuron_inst_wen,
    output logic [7:0]           neuron_inst_address,
    output logic [1:0]           neuron_inst_data_out,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 hdr_error,
    output logic                 csum_error
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_PARAM, S_INST_WAIT, S_INST_UNPACK, S_CSUM
    } state_t;
    localparam state_t S_END = S_CSUM;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_PARAM, S_INST_WAIT, S_INST_UNPACK
    } state_t;
    localparam state_t S_END = S_IDLE;
`endif
    localparam logic [4:0] LP_NC = 5'(NUM_CORES);

    state_t                r_state;
    state_t                w_state_nx;
    logic                  r_run;
    logic [3:0]            r_core;
    logic [15:0]           r_cnt;
    logic [3:0]            r_slot;
    logic [7:0]            r_addr;
    logic [7:0]            r_addr_q;
    logic [31:0]           r_word;
    logic [1:0]            r_data_q;
    logic [NUM_CORES-1:0]  r_param_wen;
    logic [31:0]           r_param_data;
    logic                  r_fd;
    logic                  r_hdr_err;
    logic                  w_fire;
    logic                  w_op_a;
    logic                  w_op_b;
    logic                  w_hdr_bad;
    logic                  w_hdr_ok;
    logic                  w_last_slot;
    logic                  w_fd_nx;
    logic [NUM_CORES-1:0]  w_core_oh;
    logic [1:0]            w_slot_data;

    assign w_fire      = s_valid && s_ready;
    assign w_op_a      = s_data[31:28] == 4'hA;
    assign w_op_b      = s_data[31:28] == 4'hB;
    assign w_hdr_bad   = !(w_op_a || w_op_b)
                       || ({1'b0, s_data[27:24]} >= LP_NC)
                       || (w_op_b && s_data[15:0] > 16'd16);
    assign w_hdr_ok    = (r_state == S_IDLE) && w_fire && !w_hdr_bad;
    assign w_last_slot = r_slot == 4'hF;
    assign w_core_oh   = NUM_CORES'(1) << r_core;
    assign w_slot_data = r_word[{r_slot, 1'b0} +: 2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_hdr_ok && s_data[15:0] != 16'd0)
                    w_state_nx = w_op_a ? S_PARAM : S_INST_WAIT;
            end
            S_PARAM: begin
                if (w_fire && r_cnt == 16'd1) w_state_nx = S_END;
            end
            S_INST_WAIT: begin
                if (w_fire) w_state_nx = S_INST_UNPACK;
            end
            S_INST_UNPACK: begin
                if (w_last_slot)
                    w_state_nx = (r_cnt == 16'd0) ? S_END : S_INST_WAIT;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (w_fire) w_state_nx = S_IDLE;
            end
`endif
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Instruction buses show the live slot while unpacking, else the last slot sent.
    always_comb begin
        s_ready              = r_run && (r_state != S_INST_UNPACK);
        busy                 = r_state != S_IDLE;
        neuron_inst_wen      = '0;
        neuron_inst_address  = r_addr_q;
        neuron_inst_data_out = r_data_q;
        if (r_state == S_INST_UNPACK) begin
            neuron_inst_wen      = w_core_oh;
            neuron_inst_address  = r_addr;
            neuron_inst_data_out = w_slot_data;
        end
    end

    assign param_wen      = r_param_wen;
    assign param_data_out = r_param_data;
    assign frame_done     = r_fd;
    assign hdr_error      = r_hdr_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run        <= 1'b0;
            r_core       <= '0;
            r_cnt        <= '0;
            r_slot       <= '0;
            r_addr       <= '0;
            r_addr_q     <= '0;
            r_word       <= '0;
            r_data_q     <= '0;
            r_param_wen  <= '0;
            r_param_data <= '0;
            r_fd         <= 1'b0;
            r_hdr_err    <= 1'b0;
        end else begin
            r_run       <= 1'b1;
            r_param_wen <= '0;
            r_fd        <= w_fd_nx;
            r_hdr_err   <= (r_hdr_err && !err_clr)
                        || ((r_state == S_IDLE) && w_fire && w_hdr_bad);
            if (w_hdr_ok) begin
                r_core <= s_data[27:24];
                r_cnt  <= s_data[15:0];
                if (w_op_b) r_addr <= '0;
            end
            if (r_state == S_PARAM && w_fire) begin
                r_param_wen  <= w_core_oh;
                r_param_data <= s_data;
                r_cnt        <= r_cnt - 16'd1;
            end
            if (r_state == S_INST_WAIT && w_fire) begin
                r_word <= s_data;
                r_cnt  <= r_cnt - 16'd1;
            end
            if (r_state == S_INST_UNPACK) begin
                r_slot   <= r_slot + 4'd1;
                r_addr   <= r_addr + 8'd1;
                r_addr_q <= r_addr;
                r_data_q <= w_slot_data;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] r_xor;
    logic        r_csum_err;

    assign w_fd_nx    = (w_hdr_ok && s_data[15:0] == 16'd0)
                      || (r_state == S_CSUM && w_fire);
    assign csum_error = r_csum_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_xor      <= '0;
            r_csum_err <= 1'b0;
        end else begin
            r_csum_err <= (r_csum_err && !err_clr)
                       || (r_state == S_CSUM && w_fire && s_data != r_xor);
            if (w_hdr_ok)
                r_xor <= '0;
            else if ((r_state == S_PARAM || r_state == S_INST_WAIT) && w_fire)
                r_xor <= r_xor ^ s_data;
        end
    end
`else
    logic r_fd_pend;

    // Param frames finish one cycle after their last write is presented.
    assign w_fd_nx    = (w_hdr_ok && s_data[15:0] == 16'd0)
                      || r_fd_pend
                      || (r_state == S_INST_UNPACK && w_last_slot && r_cnt == 16'd0);
    assign csum_error = 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_fd_pend <= 1'b0;
        else          r_fd_pend <= (r_state == S_PARAM) && w_fire && (r_cnt == 16'd1);
    end
`endif

endmodule

// File: tb/tb_core_param_loader.sv
// Bench for core_param_loader: directed frames checked against a cycle-tagged write model.
// Checksum tests run when LOADER_CHECKSUM_EN is defined.
module tb_core_param_loader;

    typedef struct {
        bit          kind;
        logic [5:0]  wen;
        logic [31:0] data;
        logic [7:0]  addr;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        err_clr;
    logic [5:0]  param_wen;
    logic [31:0] param_data_out;
    logic [5:0]  neuron_inst_wen;
    logic [7:0]  neuron_inst_address;
    logic [1:0]  neuron_inst_data_out;
    logic        busy;
    logic        frame_done;
    logic        hdr_error;
    logic        csum_error;

    always #5 clk = ~clk;

    core_param_loader #(.NUM_CORES(6)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .s_data               (s_data),
        .s_valid              (s_valid),
        .s_ready              (s_ready),
        .err_clr              (err_clr),
        .param_wen            (param_wen),
        .param_data_out       (param_data_out),
        .neuron_inst_wen      (neuron_inst_wen),
        .neuron_inst_address  (neuron_inst_address),
        .neuron_inst_data_out (neuron_inst_data_out),
        .busy                 (busy),
        .frame_done           (frame_done),
        .hdr_error            (hdr_error),
        .csum_error           (csum_error)
    );

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          chk_en = 1'b0;
    wr_t         eq[$];
    wr_t         obs_p[$];
    wr_t         obs_i[$];
    int          fdq[$];
    int          obs_fd[$];
    int          waits_q[$];
    logic [31:0] pay[$];
    bit          m_hdr = 1'b0;
    bit          m_csum = 1'b0;
    logic [31:0] m_lp = '0;
    logic [7:0]  m_la = '0;
    logic [1:0]  m_ld = '0;
`ifdef LOADER_CHECKSUM_EN
    bit          ck_flip = 1'b0;
`endif

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm, input int a, input int e);
        checks++;
        failures++;
        $display("FAIL %s: got %0d, expected %0d", nm, a, e);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_t e;
        if (chk_en) begin
            check("onehot", 64'($countones({param_wen, neuron_inst_wen}) <= 1), 64'd1);
            while (eq.size() > 0 && eq[0].cyc < cyc) begin
                fail("missed_write", cyc, eq[0].cyc);
                void'(eq.pop_front());
            end
            if (|{param_wen, neuron_inst_wen}) begin
                if (eq.size() == 0) fail("unexpected_write", cyc, -1);
                else begin
                    e = eq.pop_front();
                    check("write_cycle", 64'(cyc), 64'(e.cyc));
                    check("write_enable", 64'({param_wen, neuron_inst_wen}),
                          e.kind ? 64'({6'b0, e.wen}) : 64'({e.wen, 6'b0}));
                    if (e.kind) begin
                        m_la = e.addr;
                        m_ld = e.data[1:0];
                    end else m_lp = e.data;
                end
            end
            check("param_bus", 64'(param_data_out), 64'(m_lp));
            check("inst_bus", 64'({neuron_inst_address, neuron_inst_data_out}), 64'({m_la, m_ld}));
            while (fdq.size() > 0 && fdq[0] < cyc) begin
                fail("missed_done", cyc, fdq[0]);
                void'(fdq.pop_front());
            end
            if (frame_done) begin
                if (fdq.size() == 0) fail("unexpected_done", cyc, -1);
                else check("done_cycle", 64'(cyc), 64'(fdq.pop_front()));
            end
            check("hdr_error", 64'(hdr_error), 64'(m_hdr));
            check("csum_error", 64'(csum_error), 64'(m_csum));
        end
        if (|param_wen) obs_p.push_back('{1'b0, param_wen, param_data_out, 8'd0, cyc});
        if (|neuron_inst_wen)
            obs_i.push_back('{1'b1, neuron_inst_wen, 32'(neuron_inst_data_out), neuron_inst_address, cyc});
        if (frame_done) obs_fd.push_back(cyc);
    end

    task automatic xfer(input logic [31:0] w, output int ac, output int nw);
        bit acc;
        bit done;
        done = 1'b0;
        nw = 0;
        ac = 0;
        s_valid = 1'b1;
        s_data = w;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            nw++;
            acc = s_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                done = 1'b1;
                ac = cyc;
            end
        end
        s_valid = 1'b0;
        if (!done) fail("handshake_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(posedge clk);
        if (n > 0) #1;
    endtask

    // Sends header + pay[0..N-1] (+ checksum) and records what the loader must do.
    task automatic frame(input logic [31:0] hdr, input int maxgap);
        logic [3:0]  op;
        logic [3:0]  core;
        logic [31:0] wd;
        logic [31:0] x;
        logic [7:0]  a;
        int          n;
        int          ac;
        int          w;
        bit          bad;
        wr_t         e;
        op = hdr[31:28];
        core = hdr[27:24];
        n = int'(hdr[15:0]);
        bad = !(op == 4'hA || op == 4'hB) || core >= 4'd6 || (op == 4'hB && n > 16);
        xfer(hdr, ac, w);
        if (bad) begin
            m_hdr = 1'b1;
            return;
        end
        if (n == 0) begin
            fdq.push_back(ac);
            return;
        end
        x = '0;
        a = '0;
        for (int i = 0; i < n; i++) begin
            if (maxgap > 0) idle(int'($urandom_range(0, maxgap)));
            wd = pay[i];
            xfer(wd, ac, w);
            waits_q.push_back(w);
            x = x ^ wd;
            e.wen = 6'(1) << core;
            if (op == 4'hA) begin
                e.kind = 1'b0;
                e.data = wd;
                e.addr = '0;
                e.cyc = ac;
                eq.push_back(e);
            end else begin
                for (int k = 0; k < 16; k++) begin
                    e.kind = 1'b1;
                    e.data = 32'(wd[2*k +: 2]);
                    e.addr = a;
                    e.cyc = ac + k;
                    eq.push_back(e);
                    a = a + 8'd1;
                end
            end
`ifndef LOADER_CHECKSUM_EN
            if (i == n - 1) fdq.push_back(op == 4'hA ? ac + 1 : ac + 16);
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        if (maxgap > 0) idle(int'($urandom_range(0, maxgap)));
        xfer(x ^ 32'(ck_flip), ac, w);
        fdq.push_back(ac);
        if (ck_flip) m_csum = 1'b1;
`endif
    endtask

    task automatic clr_err();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        m_hdr = 1'b0;
        m_csum = 1'b0;
    endtask

    task automatic clr_logs();
        obs_p.delete();
        obs_i.delete();
        obs_fd.delete();
        waits_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    initial begin
        int ac;
        int w;
        reset_n = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        err_clr = 1'b0;
        #12;
        check("rst_ready", 64'(s_ready), 64'd0);
        check("rst_outs", 64'({param_wen, neuron_inst_wen, busy, frame_done, hdr_error, csum_error}), 64'd0);
        check("rst_buses", 64'({param_data_out, neuron_inst_address, neuron_inst_data_out}), 64'd0);
        #6;
        reset_n = 1'b1;
        #1;
        check("ready_before_clk", 64'(s_ready), 64'd0);
        @(posedge clk);
        #1;
        check("ready_after_clk", 64'(s_ready), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);
        chk_en = 1'b1;

        // parameter block, back-to-back
        clr_logs();
        pay = '{32'd1, 32'd2, 32'd3};
        frame(32'hA200_0003, 0);
        idle(3);
        check("t1_count", 64'(obs_p.size()), 64'd3);
        if (obs_p.size() == 3) begin
            check("t1_data01", {obs_p[0].data, obs_p[1].data}, {32'd1, 32'd2});
            check("t1_data2", 64'(obs_p[2].data), 64'd3);
            check("t1_wen", 64'({obs_p[0].wen, obs_p[2].wen}), 64'({6'b000100, 6'b000100}));
            check("t1_consec", 64'(obs_p[2].cyc - obs_p[0].cyc), 64'd2);
            check("t1_done_n", 64'(obs_fd.size()), 64'd1);
            if (obs_fd.size() == 1)
                check("t1_done_cyc", 64'(obs_fd[0] - obs_p[2].cyc), 64'd1);
        end

        // instruction block
        clr_logs();
        pay = '{32'hFFFF_FFFF, 32'h0000_0000};
        frame(32'hB500_0002, 0);
        idle(20);
        check("t2_count", 64'(obs_i.size()), 64'd32);
        if (obs_i.size() == 32) begin
            check("t2_s0", 64'({obs_i[0].wen, obs_i[0].addr, obs_i[0].data[1:0]}),
                  64'({6'b100000, 8'd0, 2'd3}));
            check("t2_s15", 64'({obs_i[15].wen, obs_i[15].addr, obs_i[15].data[1:0]}),
                  64'({6'b100000, 8'd15, 2'd3}));
            check("t2_s16", 64'({obs_i[16].wen, obs_i[16].addr, obs_i[16].data[1:0]}),
                  64'({6'b100000, 8'd16, 2'd0}));
            check("t2_s31", 64'({obs_i[31].wen, obs_i[31].addr, obs_i[31].data[1:0]}),
                  64'({6'b100000, 8'd31, 2'd0}));
            check("t2_word_gap", 64'(obs_i[16].cyc - obs_i[15].cyc), 64'd2);
        end
        if (waits_q.size() == 2)
            check("t2_ready_low", 64'(waits_q[1]), 64'd17);
        else fail("t2_waits", waits_q.size(), 2);
        check("t2_done_n", 64'(obs_fd.size()), 64'd1);

        // header errors
        clr_logs();
        frame(32'hA600_0001, 0);
        check("t3_hdr_set", 64'(hdr_error), 64'd1);
        pay = '{32'hDEAD_BEEF};
        frame(32'hA000_0001, 0);
        idle(3);
        check("t3_next_hdr", 64'(obs_p.size()), 64'd1);
        if (obs_p.size() == 1)
            check("t3_write", 64'({obs_p[0].wen, obs_p[0].data}), 64'({6'b000001, 32'hDEAD_BEEF}));
        clr_err();
        check("t3_cleared", 64'(hdr_error), 64'd0);
        frame(32'hB000_0011, 0);
        check("t3_n17", 64'(hdr_error), 64'd1);
        err_clr = 1'b1;
        frame(32'h3000_0001, 0);
        err_clr = 1'b0;
        m_csum = 1'b0;
        idle(1);
        check("t3_set_wins", 64'(hdr_error), 64'd1);
        clr_logs();
        frame(32'hA100_0000, 0);
        idle(2);
        check("t3_n0_done", 64'({obs_fd.size(), obs_p.size()}), 64'({32'd1, 32'd0}));

        // stalls inside a parameter frame
        clr_logs();
        pay = '{32'd11, 32'd22, 32'd33, 32'd44};
        frame(32'hA000_0004, 3);
        idle(4);
        check("t4_count", 64'(obs_p.size()), 64'd4);
        if (obs_p.size() == 4)
            check("t4_order", {obs_p[0].data, obs_p[3].data}, {32'd11, 32'd44});

        // reset in the middle of unpacking
        chk_en = 1'b0;
        xfer(32'hB100_0002, ac, w);
        xfer(32'h5555_5555, ac, w);
        repeat (5) @(posedge clk);
        #3;
        check("t5_unpacking", 64'({neuron_inst_wen, busy}), 64'({6'b000010, 1'b1}));
        reset_n = 1'b0;
        #1;
        check("t5_rst_wen", 64'({param_wen, neuron_inst_wen}), 64'd0);
        check("t5_rst_state", 64'({s_ready, busy, hdr_error}), 64'd0);
        eq.delete();
        fdq.delete();
        m_hdr = 1'b0;
        m_csum = 1'b0;
        m_lp = '0;
        m_la = '0;
        m_ld = '0;
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("t5_ready", 64'(s_ready), 64'd1);
        chk_en = 1'b1;
        clr_logs();
        pay = '{32'h1234_5678};
        frame(32'hA500_0001, 0);
        idle(4);
        check("t5_fresh", 64'(obs_p.size()), 64'd1);
        if (obs_p.size() == 1)
            check("t5_write", 64'({obs_p[0].wen, obs_p[0].data}), 64'({6'b100000, 32'h1234_5678}));

`ifdef LOADER_CHECKSUM_EN
        clr_logs();
        pay = '{32'd5, 32'd3};
        ck_flip = 1'b0;
        frame(32'hA300_0002, 0);
        idle(3);
        check("t6_ck_good", 64'(csum_error), 64'd0);
        ck_flip = 1'b1;
        frame(32'hA300_0002, 0);
        idle(3);
        ck_flip = 1'b0;
        check("t6_ck_bad", 64'(csum_error), 64'd1);
        check("t6_done_n", 64'(obs_fd.size()), 64'd2);
        check("t6_writes", 64'(obs_p.size()), 64'd4);
`endif

        idle(20);
        check("end_writes_drained", 64'(eq.size()), 64'd0);
        check("end_done_drained", 64'(fdq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
